mcu_core_param: RTL and testbench

- Parametrised successor to the fixed 16-bit multi-cycle CPU.
- Data width, address width and register count are parameters.
- Memory is external, accessed through a req/ack word bus, so program/data RAM and wait states live outside the core.
- Adds carry flag, conditional jumps, handshaked I/O and a terminal halt state. Sits between the program RAM and the board I/O registers.

---
 rtl/mcu_core_param.sv | 201 ++++++++++++++++++++
 tb/tb_mcu_core_param.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_core_param.sv
// rtl/mcu_core_param.sv - parametrised multi-cycle CPU core with req/ack word bus and handshaked I/O
// Define CPU_RETIRE_EN to add the retire_valid/retire_pc instruction trace outputs.
module mcu_core_param #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter int                NREG     = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] io_in_data,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    output logic [DATA_W-1:0] io_out_data,
    output logic              io_out_valid,
    output logic              halted
`ifdef CPU_RETIRE_EN
    ,
    output logic              retire_valid,
    output logic [ADDR_W-1:0] retire_pc
`endif
);
    localparam int RI_W = $clog2(NREG);

    localparam logic [3:0] OP_HLT = 4'h1, OP_MOV = 4'h2, OP_LDI = 4'h3, OP_LD  = 4'h4;
    localparam logic [3:0] OP_ST  = 4'h5, OP_ADD = 4'h6, OP_SUB = 4'h7, OP_AND = 4'h8;
    localparam logic [3:0] OP_OR  = 4'h9, OP_XOR = 4'hA, OP_CMP = 4'hB, OP_SH  = 4'hC;
    localparam logic [3:0] OP_JCC = 4'hD, OP_IN  = 4'hE, OP_OUT = 4'hF;

    typedef enum logic [2:0] {S_FETCH, S_IMM, S_EXEC, S_MEM, S_IOW, S_HALT} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [3:0]        ir_op;
    logic [RI_W-1:0]   ir_rd, ir_rs;
    logic [2:0]        ir_cc;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] regs [NREG];
    logic              flag_z, flag_c, flag_a;
    logic [DATA_W-1:0] rd_v, rs_v, mem_ptr, alu_res;
    logic [DATA_W:0]   sum;
    logic              alu_c, alu_a, alu_wr, alu_flags, taken;

    assign rd_v = regs[ir_rd];
    assign rs_v = regs[ir_rs];
    assign sum  = {1'b0, rd_v} + {1'b0, rs_v};

    always_comb begin
        alu_res   = '0;
        alu_c     = flag_c;
        alu_a     = flag_a;
        alu_wr    = 1'b0;
        alu_flags = 1'b0;
        case (ir_op)
            OP_MOV: begin alu_res = rs_v; alu_wr = 1'b1; end
            OP_LDI: begin alu_res = imm;  alu_wr = 1'b1; end
            OP_ADD: begin
                alu_res = sum[DATA_W-1:0]; alu_c = sum[DATA_W];
                alu_wr = 1'b1; alu_flags = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                alu_res = rd_v - rs_v; alu_c = rd_v < rs_v; alu_a = rd_v > rs_v;
                alu_wr = (ir_op == OP_SUB); alu_flags = 1'b1;
            end
            OP_AND: begin alu_res = rd_v & rs_v; alu_c = 1'b0; alu_wr = 1'b1; alu_flags = 1'b1; end
            OP_OR:  begin alu_res = rd_v | rs_v; alu_c = 1'b0; alu_wr = 1'b1; alu_flags = 1'b1; end
            OP_XOR: begin alu_res = rd_v ^ rs_v; alu_c = 1'b0; alu_wr = 1'b1; alu_flags = 1'b1; end
            // Logical shifts by the full register value already yield 0 for amounts >= DATA_W
            OP_SH: begin
                alu_res = ir_cc[0] ? (rd_v >> rs_v) : (rd_v << rs_v);
                alu_wr = 1'b1; alu_flags = 1'b1;
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (ir_cc)
            3'd0: taken = 1'b1;
            3'd1: taken = flag_z;
            3'd2: taken = !flag_z;
            3'd3: taken = flag_c;
            3'd4: taken = !flag_c;
            3'd5: taken = flag_a;
            3'd6: taken = !flag_a;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= S_FETCH;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: if (mem_ack)
                state_nxt = (mem_rdata[15:12] == OP_LDI || mem_rdata[15:12] == OP_JCC) ? S_IMM : S_EXEC;
            S_IMM:   if (mem_ack) state_nxt = S_EXEC;
            S_EXEC: begin
                case (ir_op)
                    OP_HLT:       state_nxt = S_HALT;
                    OP_LD, OP_ST: state_nxt = S_MEM;
                    OP_IN:        state_nxt = S_IOW;
                    default:      state_nxt = S_FETCH;
                endcase
            end
            S_MEM:   if (mem_ack) state_nxt = S_FETCH;
            S_IOW:   if (io_in_valid) state_nxt = S_FETCH;
            default: state_nxt = S_HALT;
        endcase
    end

    // Gating with rst keeps the bus quiet during reset even though state already reads FETCH
    assign mem_req     = rst && (state == S_FETCH || state == S_IMM || state == S_MEM);
    assign mem_we      = (state == S_MEM) && (ir_op == OP_ST);
    assign mem_ptr     = (ir_op == OP_ST) ? rd_v : rs_v;
    assign mem_addr    = (state == S_MEM) ? mem_ptr[ADDR_W-1:0] : pc;
    assign mem_wdata   = rs_v;
    assign io_in_ready = (state == S_IOW);
    assign halted      = (state == S_HALT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc           <= RESET_PC;
            ir_op        <= '0;
            ir_rd        <= '0;
            ir_rs        <= '0;
            ir_cc        <= '0;
            imm          <= '0;
            flag_z       <= 1'b0;
            flag_c       <= 1'b0;
            flag_a       <= 1'b0;
            io_out_data  <= '0;
            io_out_valid <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            io_out_valid <= 1'b0;
            case (state)
                S_FETCH: if (mem_ack) begin
                    ir_op <= mem_rdata[15:12];
                    ir_rd <= mem_rdata[9 +: RI_W];
                    ir_rs <= mem_rdata[6 +: RI_W];
                    ir_cc <= mem_rdata[2:0];
                    pc    <= pc + 1'b1;
                end
                S_IMM: if (mem_ack) begin
                    imm <= mem_rdata;
                    pc  <= pc + 1'b1;
                end
                S_EXEC: begin
                    if (alu_wr) regs[ir_rd] <= alu_res;
                    if (alu_flags) begin
                        flag_z <= (alu_res == '0);
                        flag_c <= alu_c;
                        flag_a <= alu_a;
                    end
                    if (ir_op == OP_JCC && taken) pc <= imm[ADDR_W-1:0];
                    if (ir_op == OP_OUT) begin
                        io_out_data  <= rs_v;
                        io_out_valid <= 1'b1;
                    end
                end
                S_MEM: if (mem_ack && ir_op == OP_LD) regs[ir_rd] <= mem_rdata;
                S_IOW: if (io_in_valid) regs[ir_rd] <= io_in_data;
                default: ;
            endcase
        end
    end

`ifdef CPU_RETIRE_EN
    logic [ADDR_W-1:0] op_pc;

    always_ff @(posedge clk) begin
        if (!rst)                           op_pc <= RESET_PC;
        else if (state == S_FETCH && mem_ack) op_pc <= pc;
    end

    always_comb begin
        retire_valid = 1'b0;
        case (state)
            S_EXEC:  retire_valid = !(ir_op == OP_LD || ir_op == OP_ST || ir_op == OP_IN);
            S_MEM:   retire_valid = mem_ack;
            S_IOW:   retire_valid = io_in_valid;
            default: retire_valid = 1'b0;
        endcase
        retire_valid = retire_valid && rst;
    end

    assign retire_pc = op_pc;
`endif

endmodule

// File: tb/tb_mcu_core_param.sv
// tb/tb_mcu_core_param.sv - self-checking bench for mcu_core_param against an instruction-level model
module tb_mcu_core_param;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] io_in_data, io_out_data;
    logic        io_in_valid, io_in_ready, io_out_valid, halted;

    always #5 clk = ~clk;

    mcu_core_param dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .io_in_data(io_in_data), .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
        .io_out_data(io_out_data), .io_out_valid(io_out_valid), .halted(halted)
    );

    // bus-side RAM with programmable wait states
    logic [15:0] mem  [0:1023];
    logic [15:0] prog [0:1023];
    bit          do_load = 1'b0;
    int          wait_n = 0;
    int          wcnt = 0;
    assign mem_ack   = mem_req && (wcnt >= wait_n);
    assign mem_rdata = mem[mem_addr[9:0]];
    always @(posedge clk) begin
        if (do_load) mem <= prog;
        else if (mem_req && mem_we && mem_ack) mem[mem_addr[9:0]] <= mem_wdata;
        if (mem_req && !mem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    // output capture and request-stability recorder
    logic [15:0] dut_outs [$];
    logic [15:0] sv_addr, sv_wdata;
    logic        sv_we;
    int          stab_n = 0;
    bit          stab_bad = 1'b0;
    always @(negedge clk) begin
        if (io_out_valid) dut_outs.push_back(io_out_data);
        if (mem_req) begin
            if (wcnt == 0) begin
                sv_addr <= mem_addr; sv_wdata <= mem_wdata; sv_we <= mem_we;
            end else begin
                stab_n <= stab_n + 1;
                if (mem_addr !== sv_addr || mem_we !== sv_we || (mem_we && mem_wdata !== sv_wdata))
                    stab_bad <= 1'b1;
            end
        end
    end

    int n_cmp = 0, n_err = 0;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // assembler
    int pa;
    int in_q [$];
    task automatic new_prog;
        for (int i = 0; i < 1024; i++) prog[i] = 16'h0000;
        pa = 0;
        in_q.delete();
    endtask
    task automatic emit(input int w);
        prog[pa % 1024] = w[15:0];
        pa++;
    endtask
    function automatic int ins(input int op, input int rd, input int rs, input int cc);
        return (op << 12) | (rd << 9) | (rs << 6) | cc;
    endfunction
    task automatic a_ldi(input int rd, input int v); emit(ins(3, rd, 0, 0)); emit(v); endtask
    task automatic a_jcc(input int cc, input int t); emit(ins(13, 0, 0, cc)); emit(t); endtask
    task automatic a_out(input int rs); emit(ins(15, 0, rs, 0)); endtask
    task automatic a_hlt; emit(ins(1, 0, 0, 0)); endtask
    // r7 ends up 0 if the condition is taken, 1 otherwise, and is then output
    task automatic a_dump(input int cc);
        a_ldi(7, 0); a_jcc(cc, pa + 4); a_ldi(7, 1); a_out(7);
    endtask

    // instruction-level reference model
    int mm [0:1023];
    int mr [0:7];
    bit mz, mc, ma;
    int exp_outs [$];
    task automatic run_model(input int w, output int cyc, output int acc);
        int pc, iw, op, rd, rs, imm, a, b, r;
        bit tk;
        for (int i = 0; i < 1024; i++) mm[i] = int'(prog[i]);
        for (int i = 0; i < 8; i++) mr[i] = 0;
        mz = 0; mc = 0; ma = 0; pc = 0; cyc = 0; acc = 0;
        exp_outs.delete();
        for (int step = 0; step < 5000; step++) begin
            iw = mm[pc % 1024]; pc = (pc + 1) % 65536; cyc += 1 + w; acc++;
            op = (iw >> 12) & 15; rd = (iw >> 9) & 7; rs = (iw >> 6) & 7; imm = 0;
            if (op == 3 || op == 13) begin
                imm = mm[pc % 1024]; pc = (pc + 1) % 65536; cyc += 1 + w; acc++;
            end
            cyc++;
            a = mr[rd]; b = mr[rs];
            case (op)
                1: return;
                2: mr[rd] = b;
                3: mr[rd] = imm;
                4: begin mr[rd] = mm[b % 1024]; cyc += 1 + w; acc++; end
                5: begin mm[a % 1024] = b; cyc += 1 + w; acc++; end
                6: begin r = a + b; mc = (r > 65535); r = r & 65535; mz = (r == 0); mr[rd] = r; end
                7, 11: begin
                    r = (a - b) & 65535; mc = (a < b); ma = (a > b); mz = (r == 0);
                    if (op == 7) mr[rd] = r;
                end
                8, 9, 10: begin
                    r = (op == 8) ? (a & b) : (op == 9) ? (a | b) : (a ^ b);
                    mc = 0; mz = (r == 0); mr[rd] = r;
                end
                12: begin
                    if (b >= 16) r = 0;
                    else if ((iw & 1) == 1) r = a >> b;
                    else r = (a << b) & 65535;
                    mz = (r == 0); mr[rd] = r;
                end
                13: begin
                    case (iw & 7)
                        0: tk = 1; 1: tk = mz; 2: tk = !mz; 3: tk = mc;
                        4: tk = !mc; 5: tk = ma; 6: tk = !ma; default: tk = 0;
                    endcase
                    if (tk) pc = imm;
                end
                14: begin mr[rd] = in_q.pop_front(); cyc++; end
                15: exp_outs.push_back(b);
                default: ;
            endcase
        end
    endtask

    int out_base;
    task automatic tick; @(posedge clk); #2; endtask

    task automatic start_run(input int w);
        wait_n = w; io_in_valid = 1'b0; rst = 1'b0;
        do_load = 1'b1; tick; do_load = 1'b0; tick;
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_in_ready", 32'(io_in_ready), 0);
        check("rst_out_valid", 32'(io_out_valid), 0);
        check("rst_out_data", 32'(io_out_data), 0);
        check("rst_halted", 32'(halted), 0);
        out_base = dut_outs.size();
        rst = 1'b1;
    endtask

    task automatic run_to_halt(output int cyc);
        cyc = 0;
        while (!halted && cyc < 3000) begin tick; cyc++; end
        check("halt_reached", 32'(halted), 1);
        tick; tick;
    endtask

    task automatic cmp_outs(input string tag);
        check({tag, "_count"}, 32'(dut_outs.size() - out_base), 32'(exp_outs.size()));
        for (int i = 0; i < exp_outs.size() && out_base + i < dut_outs.size(); i++)
            check(tag, 32'(dut_outs[out_base + i]), 32'(exp_outs[i]));
    endtask

    int ops [0:7] = '{2, 6, 7, 8, 9, 10, 11, 12};

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int mcyc, macc, dcyc, rc, st0, w, sel, rd, rs;
        bit found;
        rst = 1'b0; io_in_valid = 1'b0; io_in_data = 16'h0000;

        // basic add/out/halt with zero-wait RAM
        new_prog;
        a_ldi(1, 'h1234); a_ldi(2, 'h0001); emit(ins(6, 1, 2, 0)); a_out(1); a_hlt;
        run_model(0, mcyc, macc);
        start_run(0); run_to_halt(dcyc);
        check("t1_cycles", 32'(dcyc), 32'(mcyc));
        cmp_outs("t1_out");
        check("t1_last_out", 32'(io_out_data), 32'h1235);

        // carry/zero/above flags via ADD overflow and CMP
        new_prog;
        a_ldi(0, 'hFFFF); a_ldi(1, 1); emit(ins(6, 0, 1, 0));
        a_dump(1); a_dump(3); a_dump(5); a_out(0);
        emit(ins(11, 1, 0, 0));
        a_dump(1); a_dump(3); a_dump(5); a_hlt;
        run_model(0, mcyc, macc);
        start_run(0); run_to_halt(dcyc);
        check("t2_cycles", 32'(dcyc), 32'(mcyc));
        cmp_outs("t2_flags");

        // countdown loop with JCC !Z
        new_prog;
        a_ldi(0, 3); a_ldi(1, 1);
        emit(ins(7, 0, 1, 0)); a_out(0); a_jcc(2, 4); a_hlt;
        run_model(0, mcyc, macc);
        start_run(0); run_to_halt(dcyc);
        check("t3_cycles", 32'(dcyc), 32'(mcyc));
        cmp_outs("t3_loop");

        // store/load through a RAM with two wait cycles
        new_prog;
        a_ldi(3, 'h0040); a_ldi(4, 'hBEEF);
        emit(ins(5, 3, 4, 0)); emit(ins(4, 5, 3, 0)); a_out(5); a_hlt;
        run_model(2, mcyc, macc);
        start_run(2);
        st0 = stab_n;
        run_to_halt(dcyc);
        check("t4_cycles", 32'(dcyc), 32'(mcyc));
        check("t4_wait_cycles", 32'(stab_n - st0), 32'(macc * 2));
        check("t4_bus_stable", 32'(stab_bad), 0);
        check("t4_ram", 32'(mem[64]), 32'hBEEF);
        cmp_outs("t4_ld");

        // IN with the producer late by five cycles
        new_prog;
        emit(ins(14, 2, 0, 0)); a_out(2); a_hlt;
        in_q.push_back('h00A5);
        run_model(0, mcyc, macc);
        io_in_data = 16'h00A5;
        start_run(0);
        rc = 0;
        for (int i = 0; i < 100 && !halted; i++) begin
            tick;
            if (io_in_ready) rc++;
            io_in_valid = io_in_ready && (rc >= 6);
        end
        io_in_valid = 1'b0;
        check("t5_halt", 32'(halted), 1);
        check("t5_ready_cycles", 32'(rc), 6);
        tick; tick;
        cmp_outs("t5_in");

        // reset while a load waits for its ack
        new_prog;
        a_ldi(1, 'h55); a_ldi(2, 'h80); emit(ins(4, 3, 2, 0)); a_hlt;
        start_run(6);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick;
            found = mem_req && !mem_ack && (mem_addr == 16'h0080);
        end
        check("t6_ld_pending", 32'(found), 1);
        rst = 1'b0;
        tick;
        check("t6_req_dropped", 32'(mem_req), 0);
        new_prog;
        for (int r = 0; r < 8; r++) a_out(r);
        a_hlt;
        run_model(0, mcyc, macc);
        start_run(0);
        #1;
        check("t6_first_fetch_req", 32'(mem_req), 1);
        check("t6_first_fetch_addr", 32'(mem_addr), 0);
        run_to_halt(dcyc);
        cmp_outs("t6_regs_zero");

        // randomized ALU/shift/memory programs
        for (int it = 0; it < 4; it++) begin
            w = $urandom_range(0, 2);
            new_prog;
            for (int r = 0; r < 7; r++)
                a_ldi(r, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 20) : $urandom_range(0, 65535));
            for (int k = 0; k < 30; k++) begin
                sel = $urandom_range(0, 9);
                rd = $urandom_range(0, 6);
                rs = $urandom_range(0, 5);
                if (sel < 8) emit(ins(ops[sel], rd, rs, $urandom_range(0, 1)));
                else if (sel == 8) a_dump($urandom_range(0, 7));
                else begin
                    a_ldi(6, 'h300 + $urandom_range(0, 63));
                    emit(ins(5, 6, rs, 0));
                    emit(ins(4, rd, 6, 0));
                end
            end
            for (int r = 0; r < 7; r++) a_out(r);
            a_hlt;
            run_model(w, mcyc, macc);
            start_run(w); run_to_halt(dcyc);
            check("rnd_cycles", 32'(dcyc), 32'(mcyc));
            cmp_outs("rnd_out");
        end
        check("bus_stable_all", 32'(stab_bad), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
